// File: rtl/rpn_sequencer.sv
// Control sequencer for an RPN calculator: steps A/B operand entry, operation
// commit, optional multiplier handshake with timeout, and result display.
module rpn_sequencer #(
    parameter int MULT_TIMEOUT = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Enter,
    input  logic [2:0] OpSelect,
    input  logic       Div0,
    input  logic       Mult_Done,
    output logic       LoadA,
    output logic       LoadB,
    output logic       LoadOp,
    output logic       Mult_Start,
    output logic       Busy,
    output logic       Err,
    output logic [2:0] OpLatched,
    output logic [1:0] Estado
);

    typedef enum logic [2:0] {
        S_A, S_B, S_OP, S_EXEC, S_MWAIT, S_DISP, S_ERR
    } state_t;

    localparam logic [5:0] LAST = 6'(MULT_TIMEOUT - 1);

    state_t     state;
    logic       armed;
    logic [5:0] cnt;
    logic       ev;

    // armed means Enter was seen low last cycle; reset disarms it so a level
    // held through reset release is not mistaken for a new press.
    assign ev = Enter & armed;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state      <= S_A;
            armed      <= 1'b0;
            cnt        <= '0;
            LoadA      <= 1'b0;
            LoadB      <= 1'b0;
            LoadOp     <= 1'b0;
            Mult_Start <= 1'b0;
            Busy       <= 1'b0;
            Err        <= 1'b0;
            OpLatched  <= '0;
            Estado     <= 2'b00;
        end else begin
            armed      <= ~Enter;
            LoadA      <= 1'b0;
            LoadB      <= 1'b0;
            LoadOp     <= 1'b0;
            Mult_Start <= 1'b0;
            case (state)
                S_A: if (ev) begin
                    LoadA  <= 1'b1;
                    state  <= S_B;
                    Estado <= 2'b01;
                end
                S_B: if (ev) begin
                    LoadB  <= 1'b1;
                    state  <= S_OP;
                    Estado <= 2'b10;
                end
                S_OP: if (ev) begin
                    OpLatched <= OpSelect;
                    if (OpSelect == 3'd7 && Div0) begin
                        state  <= S_ERR;
                        Err    <= 1'b1;
                        Estado <= 2'b11;
                    end else if (OpSelect == 3'd6) begin
                        Mult_Start <= 1'b1;
                        cnt        <= '0;
                        Busy       <= 1'b1;
                        state      <= S_MWAIT;
                    end else begin
                        Busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    LoadOp <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= S_DISP;
                    Estado <= 2'b11;
                end
                S_MWAIT: begin
                    // a done pulse coinciding with the last allowed cycle still counts
                    if (Mult_Done) begin
                        LoadOp <= 1'b1;
                        Busy   <= 1'b0;
                        state  <= S_DISP;
                        Estado <= 2'b11;
                    end else if (cnt == LAST) begin
                        Err    <= 1'b1;
                        Busy   <= 1'b0;
                        state  <= S_ERR;
                        Estado <= 2'b11;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DISP: if (ev) begin
                    state  <= S_A;
                    Estado <= 2'b00;
                end
                S_ERR: if (ev) begin
                    Err    <= 1'b0;
                    state  <= S_A;
                    Estado <= 2'b00;
                end
                default: begin
                    state  <= S_A;
                    Busy   <= 1'b0;
                    Estado <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: two instances (timeout 32 and 4) driven in lockstep,
// checked against a transaction-level outcome model.
module tb_rpn_sequencer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Enter = 1'b0;
    logic       Div0 = 1'b0;
    logic       Mult_Done = 1'b0;
    logic [2:0] OpSelect = 3'd0;

    logic [1:0]      la, lb, lo, ms, busy, err;
    logic [1:0][2:0] opl;
    logic [1:0][1:0] st;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    rpn_sequencer #(.MULT_TIMEOUT(32)) dut_a (
        .Clk(Clk), .Rst(Rst), .Enter(Enter), .OpSelect(OpSelect), .Div0(Div0),
        .Mult_Done(Mult_Done), .LoadA(la[0]), .LoadB(lb[0]), .LoadOp(lo[0]),
        .Mult_Start(ms[0]), .Busy(busy[0]), .Err(err[0]), .OpLatched(opl[0]),
        .Estado(st[0])
    );

    rpn_sequencer #(.MULT_TIMEOUT(4)) dut_b (
        .Clk(Clk), .Rst(Rst), .Enter(Enter), .OpSelect(OpSelect), .Div0(Div0),
        .Mult_Done(Mult_Done), .LoadA(la[1]), .LoadB(lb[1]), .LoadOp(lo[1]),
        .Mult_Start(ms[1]), .Busy(busy[1]), .Err(err[1]), .OpLatched(opl[1]),
        .Estado(st[1])
    );

    function automatic int tmo_of(input int i);
        return (i == 0) ? 32 : 4;
    endfunction

    // Outcome of one commit: error flag and number of Busy cycles.
    function automatic void predict(input int op, input int dv, input int lat,
                                    input int tmo, output bit e_err, output int e_blen);
        if (op == 7 && dv != 0) begin
            e_err = 1'b1; e_blen = 0;
        end else if (op == 6) begin
            e_err  = (lat > tmo);
            e_blen = (lat > tmo) ? tmo : lat;
        end else begin
            e_err = 1'b0; e_blen = 1;
        end
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press();
        Enter = 1'b1; tick();
        Enter = 1'b0; tick();
    endtask

    task automatic do_reset();
        Rst = 1'b0; Enter = 1'b0; Mult_Done = 1'b0; Div0 = 1'b0;
        tick(); tick();
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        int cnt;
        Rst = 1'b0; Enter = 1'b1;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (st[i] !== 2'b00 || busy[i] !== 1'b0 || err[i] !== 1'b0 || opl[i] !== 3'd0 ||
                la[i] !== 1'b0 || lb[i] !== 1'b0 || lo[i] !== 1'b0 || ms[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state[%0d] st=%b busy=%b err=%b op=%b la=%b lb=%b lo=%b ms=%b, want all zero",
                         i, st[i], busy[i], err[i], opl[i], la[i], lb[i], lo[i], ms[i]);
            end
        end
        Rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (la[0] || la[1]) cnt++;
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (st[i] !== 2'b00 || cnt != 0) begin
                bad++;
                $display("FAIL held_through_reset[%0d] st=%b loada=%0d, want 00/0", i, st[i], cnt);
            end
        end
        Enter = 1'b0; tick();
        Enter = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (la[i] !== 1'b1 || st[i] !== 2'b01) begin
                bad++;
                $display("FAIL rearm_after_reset[%0d] la=%b st=%b, want 1/01", i, la[i], st[i]);
            end
        end
        Enter = 1'b0; tick();
        do_reset();
    endtask

    task automatic run_op(input int op, input int dv, input int lat, input bit poke);
        int bc[2], lc[2], lfirst[2], msc[2];
        int multi, exp_st0;
        bit e_err, poke_eff;
        int e_blen;
        poke_eff = poke && op == 6 && lat >= 5;
        exp_st0 = (op == 7 && dv != 0) ? 3 : 2;

        OpSelect = 3'($urandom_range(0, 7));
        Enter = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (la[i] !== 1'b1 || lb[i] !== 1'b0 || st[i] !== 2'b01) begin
                bad++;
                $display("FAIL loada[%0d] la=%b lb=%b st=%b, want 1/0/01", i, la[i], lb[i], st[i]);
            end
        end
        Enter = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (la[i] !== 1'b0) begin
                bad++;
                $display("FAIL loada_width[%0d] la=%b, want 0", i, la[i]);
            end
        end
        Enter = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (lb[i] !== 1'b1 || la[i] !== 1'b0 || st[i] !== 2'b10) begin
                bad++;
                $display("FAIL loadb[%0d] lb=%b la=%b st=%b, want 1/0/10", i, lb[i], la[i], st[i]);
            end
        end
        Enter = 1'b0; tick();

        OpSelect = 3'(op); Div0 = 1'(dv); Enter = 1'b1;
        tick();
        Enter = 1'b0; Div0 = 1'b0; OpSelect = 3'($urandom_range(0, 7));
        multi = 0;
        for (int i = 0; i < 2; i++) begin
            bc[i] = 0; lc[i] = 0; lfirst[i] = -1; msc[i] = 0;
        end
        for (int k = 0; k < 50; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (busy[i]) bc[i]++;
                if (lo[i]) begin
                    lc[i]++;
                    if (lfirst[i] < 0) lfirst[i] = k;
                end
                if (ms[i] && k == 0) msc[i]++;
                if (ms[i] && k != 0) msc[i] += 100;
                if (int'(la[i]) + int'(lb[i]) + int'(lo[i]) > 1) multi++;
                if (k == 0) begin
                    total++;
                    if (opl[i] !== 3'(op) || st[i] !== 2'(exp_st0)) begin
                        bad++;
                        $display("FAIL commit[%0d] op=%b st=%b, want %b/%b", i, opl[i], st[i], 3'(op), 2'(exp_st0));
                    end
                end
            end
            Mult_Done = (op == 6 && k == lat - 1);
            Enter = poke_eff && (k == 1 || k == 3);
            tick();
        end
        Mult_Done = 1'b0; Enter = 1'b0;

        for (int i = 0; i < 2; i++) begin
            predict(op, dv, lat, tmo_of(i), e_err, e_blen);
            total++;
            if (bc[i] != e_blen) begin
                bad++;
                $display("FAIL busy_len[%0d] op=%0d lat=%0d got=%0d want=%0d", i, op, lat, bc[i], e_blen);
            end
            total++;
            if (lc[i] != (e_err ? 0 : 1)) begin
                bad++;
                $display("FAIL loadop_count[%0d] op=%0d got=%0d want=%0d", i, op, lc[i], e_err ? 0 : 1);
            end
            if (!e_err) begin
                total++;
                if (lfirst[i] != e_blen) begin
                    bad++;
                    $display("FAIL loadop_time[%0d] op=%0d got=%0d want=%0d", i, op, lfirst[i], e_blen);
                end
            end
            total++;
            if (msc[i] != ((op == 6) ? 1 : 0)) begin
                bad++;
                $display("FAIL mult_start[%0d] op=%0d got=%0d want=%0d", i, op, msc[i], (op == 6) ? 1 : 0);
            end
            total++;
            if (err[i] !== e_err || st[i] !== 2'b11 || opl[i] !== 3'(op)) begin
                bad++;
                $display("FAIL final[%0d] op=%0d err=%b st=%b opl=%b want %b/11/%b", i, op, err[i], st[i], opl[i], e_err, 3'(op));
            end
        end
        total++;
        if (multi != 0) begin
            bad++;
            $display("FAIL strobe_overlap got=%0d want=0", multi);
        end

        Enter = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (st[i] !== 2'b00 || err[i] !== 1'b0 || opl[i] !== 3'(op)) begin
                bad++;
                $display("FAIL return_a[%0d] st=%b err=%b opl=%b want 00/0/%b", i, st[i], err[i], opl[i], 3'(op));
            end
        end
        Enter = 1'b0; tick();
    endtask

    task automatic test_held_enter();
        int cnt[2];
        cnt[0] = 0; cnt[1] = 0;
        Enter = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            for (int i = 0; i < 2; i++) if (la[i]) cnt[i]++;
        end
        Enter = 1'b0; tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cnt[i] != 1 || st[i] !== 2'b01) begin
                bad++;
                $display("FAIL held_enter[%0d] loada=%0d st=%b want 1/01", i, cnt[i], st[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mwait();
        int lcnt;
        press(); press();
        OpSelect = 3'd6; Enter = 1'b1; tick();
        Enter = 1'b0; tick(); tick();
        Rst = 1'b0; tick();
        Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (st[i] !== 2'b00 || busy[i] !== 1'b0 || opl[i] !== 3'd0 || err[i] !== 1'b0 || lo[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_mwait[%0d] st=%b busy=%b opl=%b err=%b lo=%b want 00/0/000/0/0",
                         i, st[i], busy[i], opl[i], err[i], lo[i]);
            end
        end
        Mult_Done = 1'b1; tick();
        Mult_Done = 1'b0;
        lcnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (lo[0] || lo[1] || busy[0] || busy[1] || st[0] != 2'b00 || st[1] != 2'b00) lcnt++;
            tick();
        end
        total++;
        if (lcnt != 0) begin
            bad++;
            $display("FAIL late_done_after_reset activity=%0d want=0", lcnt);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            run_op($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(1, 40),
                   1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        run_op(0, 0, 1, 1'b0);   // add
        run_op(7, 1, 1, 1'b0);   // divide by zero
        run_op(7, 0, 1, 1'b0);   // divide, nonzero divisor
        run_op(6, 0, 5, 1'b1);   // multiply, Enter pokes while waiting
        run_op(6, 0, 4, 1'b0);   // done on the last cycle of the short timeout
        run_op(6, 0, 40, 1'b0);  // both instances time out
        run_op(6, 0, 32, 1'b0);
        test_held_enter();
        test_reset_mwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 Parameter: MULT_TIMEOUT, default 32, maximum Clk cycles spent waiting for Mult_Done; legal range 1..63.
REQ-002 Clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 Rst  in  1  reset, synchronous, active-low; sampled on the rising edge of Clk.
REQ-004 Enter  in  1  debounced user Enter, level or pulse.
REQ-005 OpSelect  in  3  operation code: 0=add, 1=sub, 2=and, 3=or, 4=xor, 5=not, 6=mult, 7=div.
REQ-006 Div0  in  1  divisor-is-zero flag from the divider, combinational.
REQ-007 Mult_Done  in  1  multiplier result valid, one-cycle pulse.
REQ-008 LoadA  out  1  one-cycle strobe: push DataIn into T0.
REQ-009 LoadB  out  1  one-cycle strobe: shift T0->T1 and push DataIn into T0.
REQ-010 LoadOp  out  1  one-cycle strobe: write the ALU result into T0 and pop the stack.
REQ-011 Mult_Start  out  1  one-cycle start strobe to the multiplier.
REQ-012 Busy  out  1  high while an operation is executing.
REQ-013 Err  out  1  sticky error flag: divide-by-zero or multiplier timeout.
REQ-014 OpLatched  out  3  opcode captured at operation commit; drives the ALU and result muxes.
REQ-015 Estado  out  2  external state code: 00=A, 01=B, 10=Op, 11=Disp.

Function
REQ-016 Enter events: internal rising-edge detection; a high level of any length is one event; a new event needs Enter low for at least one cycle.
REQ-017 All outputs are registered; each strobe goes high in the cycle after the triggering event is sampled.
REQ-018 Each strobe is high for exactly one cycle; at most one of LoadA, LoadB, LoadOp is high in any cycle.
REQ-019 FSM states: S_A, S_B, S_OP, S_EXEC, S_MWAIT, S_DISP, S_ERR.
REQ-020 Estado encoding: S_A=00, S_B=01, S_OP/S_EXEC/S_MWAIT=10, S_DISP/S_ERR=11.
REQ-021 S_A + Enter event -> LoadA strobe, go to S_B.
REQ-022 S_B + Enter event -> LoadB strobe, go to S_OP.
REQ-023 S_OP + Enter event -> capture OpSelect into OpLatched, then branch as REQ-024..026.
REQ-024 OpSelect=7 with Div0=1 -> S_ERR: Err=1, no LoadOp; stack unchanged.
REQ-025 OpSelect=6 -> Mult_Start strobe, clear timeout counter, go to S_MWAIT.
REQ-026 Any other opcode, including 7 with Div0=0 -> go to S_EXEC.
REQ-027 S_EXEC: LoadOp strobe, go to S_DISP; duration is exactly one cycle.
REQ-028 S_MWAIT: counter increments each cycle.
REQ-029 S_MWAIT + Mult_Done -> LoadOp strobe, go to S_DISP.
REQ-030 S_MWAIT timeout: counter reaches MULT_TIMEOUT with no Mult_Done -> S_ERR, Err=1, no LoadOp.
REQ-031 Mult_Done in the same cycle as the timeout wins: treat as done, no error.
REQ-032 Busy=1 exactly in S_EXEC and S_MWAIT.
REQ-033 Enter events in S_EXEC or S_MWAIT are discarded, not queued.
REQ-034 S_DISP + Enter event -> S_A; OpLatched holds its value.
REQ-035 S_ERR + Enter event -> S_A, Err cleared in the same transition.
REQ-036 Mult_Done outside S_MWAIT is ignored.
REQ-037 Changes to OpSelect outside the commit cycle do not affect OpLatched.

Reset
REQ-038 Rst=0 at a Clk edge -> state S_A, Estado=00, and counter and edge-detector history cleared.
REQ-039 Rst=0 at a Clk edge -> all strobes 0, Busy=0, Err=0, OpLatched=000; takes priority over every other event.
REQ-040 Reset mid-operation (e.g. in S_MWAIT) -> no LoadOp strobe; a Mult_Done arriving after reset is ignored.
REQ-041 Enter held high through reset release does not count as an event until it goes low and high again.

Verification
REQ-042 Add flow: Enter x3 with OpSelect=0 -> LoadA, LoadB, then LoadOp one cycle after S_EXEC entry; Estado sequence 00,01,10,11; Busy high for 1 cycle.
REQ-043 Div0: OpSelect=7, Div0=1 at the third Enter -> Err=1, Estado=11, LoadOp never asserted; next Enter -> Estado=00, Err=0.
REQ-044 Multiply: OpSelect=6 and Mult_Done 5 cycles after Mult_Start -> Busy high 5 cycles, LoadOp 1 cycle after Mult_Done, OpLatched=110.
REQ-045 Timeout: MULT_TIMEOUT=4, no Mult_Done -> Err=1 after 4 cycles in S_MWAIT; a late Mult_Done is ignored.
REQ-046 Held Enter: Enter high for 10 cycles in S_A -> one LoadA only, Estado=01; Enter pulses during S_MWAIT produce no state change.
REQ-047 Reset in S_MWAIT: Rst low 1 cycle -> next cycle Estado=00, Busy=0, OpLatched=000; Mult_Done one cycle later produces no LoadOp.
